video_ds_dec: RTL
=================

VIDEO_DS_DEC -- requirements
Module: video_ds_dec

Interface
REQ-001 Parameter C_WIN, default 64: delta-sigma averaging window in CK_i cycles, fixed power of two.
REQ-002 Parameter C_SYNC_TH, default 4: a sample below this value is sync level.
REQ-003 Parameter C_HS_MIN, default 40: minimum sync-low run, in samples, that counts as horizontal sync.
REQ-004 Parameter C_VS_MIN, default 200: minimum sync-low run, in samples, that counts as a broad (vertical) pulse.
REQ-005 CK_i  in  1  system clock; the single clock of the block.
REQ-006 XSRST_i  in  1  reset, synchronous and active-low.
REQ-007 DS_i  in  1  delta-sigma video bitstream, one bit per CK_i.
REQ-008 CK_EE_i  in  1  video sample strobe, one CK_i wide, nominally every 10-11 CK_i.
REQ-009 SAMPLE_o  out  6  decoded video sample.
REQ-010 SAMPLE_EE_o  out  1  SAMPLE_o updated this cycle.
REQ-011 HS_o  out  1  one-cycle horizontal sync pulse.
REQ-012 VS_o  out  1  one-cycle vertical sync pulse.
REQ-013 LINE_o  out  9  line count since the last VS_o.

Function
REQ-014 SUM is the count of ones among the last C_WIN DS_i bits, range 0..C_WIN, held in a C_WIN-bit shift register and an up/down counter; a bit sampled in cycle t is reflected in SUM in cycle t+1.
REQ-015 SUM adds the incoming bit and subtracts the departing bit in the same cycle; simultaneous add and drop leaves SUM unchanged.
REQ-016 On CK_EE_i, SAMPLE_o <= min(SUM,63) in the next cycle, with SAMPLE_EE_o high for that one cycle.
REQ-017 The sync FSM advances only on cycles with SAMPLE_EE_o high, and has the states ACT and SYNC.
REQ-018 ACT to SYNC occurs when SAMPLE_o < C_SYNC_TH, with RUN <= 1.
REQ-019 In SYNC with SAMPLE_o < C_SYNC_TH, RUN increments, saturating at 511.
REQ-020 SYNC to ACT occurs when SAMPLE_o >= C_SYNC_TH, and the run is classified on that transition.
REQ-021 Classification, RUN < C_HS_MIN: glitch; no output; BROAD count unchanged.
REQ-022 Classification, C_HS_MIN <= RUN < C_VS_MIN: HS_o pulses; BROAD <= 0; LINE_o increments, saturating at 511.
REQ-023 Classification, RUN >= C_VS_MIN: BROAD increments, saturating at 3; when BROAD reaches 3, VS_o pulses, LINE_o <= 0, and BROAD <= 0.
REQ-024 HS_o and VS_o assert in the cycle after the classifying SAMPLE_EE_o; they are never both high.
REQ-025 When CK_EE_i is high on consecutive cycles, each strobe is honoured; SAMPLE_o and SAMPLE_EE_o follow one cycle later.
REQ-026 CK_EE_i never stalls SUM accumulation.

Reset
REQ-027 While XSRST_i is low at a CK_i edge, the following clear to 0: the shift register, SUM, SAMPLE_o, SAMPLE_EE_o, HS_o, VS_o, LINE_o, RUN, and BROAD; the FSM enters ACT.
REQ-028 Reset mid-sync discards the partial run; no HS_o or VS_o is generated for it after release.
REQ-029 Outputs are valid from the first edge after reset release; SAMPLE_o reaches steady state after C_WIN cycles.

Structure
REQ-030 Sync-state encoding (ACT, SYNC) and the default constants (C_WIN=64, C_SYNC_TH=4, C_HS_MIN=40, C_VS_MIN=200, 9-bit counter width) reside in the shared video package.
REQ-031 The moving-sum logic (shift register plus counter) is one sub-module, video_ds_sum, with ports CK_i, XSRST_i, DS_i, and SUM_o.
REQ-032 The sync FSM, line counter, and sample latch reside in video_ds_dec.

Verification
REQ-033 All-ones DS_i for 64 cycles, then CK_EE_i -> SUM=64, SAMPLE_o=63, SAMPLE_EE_o high one cycle.
REQ-034 Alternating 1/0 DS_i (the encoding of 32) for 128 cycles, strobe every 11 cycles -> SAMPLE_o=32 on every strobe after cycle 64.
REQ-035 Stream at level 0 for 58 samples, then at level 32 -> exactly one HS_o one cycle after the first level-32 SAMPLE_EE_o; LINE_o 0 -> 1.
REQ-036 Sync-level glitch of 5 samples -> no HS_o, no VS_o, LINE_o unchanged.
REQ-037 Three consecutive sync runs of 330 samples each, separated by 20 samples at level 32, after LINE_o=262 -> VS_o pulses after the third run; LINE_o=0; no HS_o.
REQ-038 XSRST_i low for 1 cycle at sample 30 of a 58-sample sync run -> all outputs 0 next cycle; no HS_o for that run; the following valid 58-sample run gives HS_o and LINE_o=1.

Source files
------------

// File: rtl/video_ds_dec_pkg.sv
// Shared types and default constants for the delta-sigma video decoder.
package video_ds_dec_pkg;

  // Default block parameters.
  localparam int unsigned DefWin    = 64;
  localparam int unsigned DefSyncTh = 4;
  localparam int unsigned DefHsMin  = 40;
  localparam int unsigned DefVsMin  = 200;

  // Width and ceiling of the run-length and line counters.
  localparam int unsigned         CntW   = 9;
  localparam logic [CntW-1:0]     CntMax = '1;

  // Three broad pulses in a row mark a vertical sync.
  localparam logic [1:0] BroadLast = 2'd2;

  typedef enum logic {
    StAct  = 1'b0,
    StSync = 1'b1
  } sync_state_e;

  // Increment that sticks at the counter ceiling.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == CntMax) ? v : v + CntW'(1);
  endfunction

endpackage

// File: rtl/video_ds_sum.sv
// Moving count of ones over the last C_WIN bits of the delta-sigma stream.
module video_ds_sum
  import video_ds_dec_pkg::*;
#(
  parameter  int unsigned C_WIN = DefWin,
  localparam int unsigned SumW  = $clog2(C_WIN) + 1
) (
  input  logic            CK_i,
  input  logic            XSRST_i,
  input  logic            DS_i,
  output logic [SumW-1:0] SUM_o
);

  logic [C_WIN-1:0] sr_q;
  logic [SumW-1:0]  sum_q;
  logic [SumW-1:0]  sum_d;
  logic             drop;

  assign drop = sr_q[C_WIN-1];

  // Add the arriving bit and remove the departing one; both together cancel.
  always_comb begin
    sum_d = sum_q;
    if (DS_i && !drop) begin
      sum_d = sum_q + SumW'(1);
    end else if (!DS_i && drop) begin
      sum_d = sum_q - SumW'(1);
    end
  end

  // Window shift register and running count.
  always_ff @(posedge CK_i) begin
    if (!XSRST_i) begin
      sr_q  <= '0;
      sum_q <= '0;
    end else begin
      sr_q  <= {sr_q[C_WIN-2:0], DS_i};
      sum_q <= sum_d;
    end
  end

  assign SUM_o = sum_q;

endmodule

// File: rtl/video_ds_dec.sv
// Delta-sigma video decoder: sample latch, sync-run classifier and line counter.
module video_ds_dec
  import video_ds_dec_pkg::*;
#(
  parameter int unsigned C_WIN     = DefWin,
  parameter int unsigned C_SYNC_TH = DefSyncTh,
  parameter int unsigned C_HS_MIN  = DefHsMin,
  parameter int unsigned C_VS_MIN  = DefVsMin
) (
  input  logic            CK_i,
  input  logic            XSRST_i,
  input  logic            DS_i,
  input  logic            CK_EE_i,
  output logic [5:0]      SAMPLE_o,
  output logic            SAMPLE_EE_o,
  output logic            HS_o,
  output logic            VS_o,
  output logic [CntW-1:0] LINE_o
);

  localparam int unsigned     SumW   = $clog2(C_WIN) + 1;
  localparam logic [5:0]      SyncTh = 6'(C_SYNC_TH);
  localparam logic [CntW-1:0] HsMin  = CntW'(C_HS_MIN);
  localparam logic [CntW-1:0] VsMin  = CntW'(C_VS_MIN);

  logic [SumW-1:0] sum;
  logic [5:0]      sample_sat;
  logic            is_sync;

  sync_state_e     state_q, state_d;
  logic [5:0]      sample_q, sample_d;
  logic            sample_ee_q, sample_ee_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic [CntW-1:0] line_q, line_d;
  logic [CntW-1:0] run_q, run_d;
  logic [1:0]      broad_q, broad_d;

  video_ds_sum #(
    .C_WIN (C_WIN)
  ) u_sum (
    .CK_i    (CK_i),
    .XSRST_i (XSRST_i),
    .DS_i    (DS_i),
    .SUM_o   (sum)
  );

  // A full window of ones reads as 64, which does not fit the 6-bit sample.
  always_comb begin
    if (32'(sum) > 32'd63) begin
      sample_sat = 6'd63;
    end else begin
      sample_sat = 6'(sum);
    end
  end

  assign is_sync = (sample_q < SyncTh);

  // Sample latch plus sync FSM; the FSM only looks at freshly latched samples.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    sample_ee_d = CK_EE_i;
    hs_d        = 1'b0;
    vs_d        = 1'b0;
    line_d      = line_q;
    run_d       = run_q;
    broad_d     = broad_q;

    if (CK_EE_i) begin
      sample_d = sample_sat;
    end

    if (sample_ee_q) begin
      unique case (state_q)
        StAct: begin
          if (is_sync) begin
            state_d = StSync;
            run_d   = CntW'(1);
          end
        end
        StSync: begin
          if (is_sync) begin
            run_d = sat_inc(run_q);
          end else begin
            state_d = StAct;
            // Classify the finished run; short runs are ignored as glitches.
            if (run_q >= VsMin) begin
              if (broad_q == BroadLast) begin
                vs_d    = 1'b1;
                line_d  = '0;
                broad_d = '0;
              end else begin
                broad_d = broad_q + 2'd1;
              end
            end else if (run_q >= HsMin) begin
              hs_d    = 1'b1;
              broad_d = '0;
              line_d  = sat_inc(line_q);
            end
          end
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CK_i) begin
    if (!XSRST_i) begin
      state_q     <= StAct;
      sample_q    <= '0;
      sample_ee_q <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      line_q      <= '0;
      run_q       <= '0;
      broad_q     <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      sample_ee_q <= sample_ee_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      line_q      <= line_d;
      run_q       <= run_d;
      broad_q     <= broad_d;
    end
  end

  assign SAMPLE_o    = sample_q;
  assign SAMPLE_EE_o = sample_ee_q;
  assign HS_o        = hs_q;
  assign VS_o        = vs_q;
  assign LINE_o      = line_q;

endmodule
